// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [3:0]       selector,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic             zero,
    output logic             msb,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SLR  = 4'd6;
    localparam logic [3:0] OP_SAR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_msb;
    logic             r_carry;

    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic             w_accept;
    logic             w_iter;
    logic             w_last;
    logic             w_load;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out0      = r_out;
    assign zero      = r_zero;
    assign msb       = r_msb;
    assign carry     = r_carry;

    assign w_accept = in_valid & in_ready;
    assign w_iter   = (selector == OP_MUL) || (selector == OP_DIVU) || (selector == OP_REMU);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_load   = (w_accept & ~w_iter) | ((r_state == S_BUSY) & w_last);

    // Single-cycle datapath, evaluated straight from the operands at accept
    logic [WIDTH:0]          w_sum;
    logic [WIDTH:0]          w_diff;
    logic [SHW-1:0]          w_amt;
    logic                    w_amt_big;
    logic signed [WIDTH-1:0] w_sin0;
    logic signed [WIDTH-1:0] w_sar;
    logic [WIDTH-1:0]        w_s_res;
    logic                    w_s_c;

    assign w_sum     = {1'b0, in0} + {1'b0, in1};
    assign w_diff    = {1'b0, in0} - {1'b0, in1};
    assign w_amt     = in1[SHW-1:0];
    assign w_amt_big = (32'(w_amt) >= 32'(WIDTH));
    assign w_sin0    = in0;
    assign w_sar     = w_sin0 >>> w_amt;

    always_comb begin
        w_s_res = in0;
        w_s_c   = 1'b0;
        case (selector)
            OP_ADD: begin
                w_s_res = w_sum[WIDTH-1:0];
                w_s_c   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_s_res = w_diff[WIDTH-1:0];
                w_s_c   = w_diff[WIDTH];
            end
            OP_AND: w_s_res = in0 & in1;
            OP_OR:  w_s_res = in0 | in1;
            OP_XOR: w_s_res = in0 ^ in1;
            OP_SLL: w_s_res = w_amt_big ? '0 : (in0 << w_amt);
            OP_SLR: w_s_res = w_amt_big ? '0 : (in0 >> w_amt);
            OP_SAR: w_s_res = w_amt_big ? {WIDTH{in0[WIDTH-1]}} : w_sar;
            default: w_s_res = in0;
        endcase
    end

    // Iterative step: r_hi:r_lo is the product (mul) or remainder:dividend/quotient (div)
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi = w_madd[WIDTH:1];
    assign w_mul_lo = {w_madd[0], r_lo[WIDTH-1:1]};

    // With a zero divisor every trial succeeds, giving all-ones quotient and remainder = dividend
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_b};
    assign w_div_ok = ~w_trial[WIDTH];
    assign w_div_hi = w_div_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_div_ok};

    assign w_step_hi = (r_op == OP_MUL) ? w_mul_hi : w_div_hi;
    assign w_step_lo = (r_op == OP_MUL) ? w_mul_lo : w_div_lo;

    logic [WIDTH-1:0] w_res;
    logic             w_res_c;

    always_comb begin
        w_res   = w_s_res;
        w_res_c = w_s_c;
        if (r_state == S_BUSY) begin
            case (r_op)
                OP_MUL: begin
                    w_res   = w_mul_lo;
                    w_res_c = |w_mul_hi;
                end
                OP_DIVU: begin
                    w_res   = w_div_lo;
                    w_res_c = ~|r_b;
                end
                default: begin
                    w_res   = w_div_hi;
                    w_res_c = ~|r_b;
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_msb   <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_BUSY) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            if (w_load) begin
                r_out   <= w_res;
                r_zero  <= ~|w_res;
                r_msb   <= w_res[WIDTH-1];
                r_carry <= w_res_c;
            end
        end
    end

    // Operand/working registers: captured once at accept, then stepped while busy
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= selector;
            r_hi <= '0;
            if (selector == OP_MUL) begin
                r_b  <= in0;
                r_lo <= in1;
            end else begin
                r_b  <= in1;
                r_lo <= in0;
            end
        end else if (r_state == S_BUSY) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
        end
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH)+1, shift-amount field width taken from in1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 in0, in1  input  WIDTH each  operands.
REQ-008 selector  input  4  opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 slr, 7 sar, 8 mul, 9 divu, 10 remu, 11-15 pass in0.
REQ-009 out_valid  output  1  result held on out0 and flags.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out0  output  WIDTH  registered result.
REQ-012 zero, msb, carry  output  1 each  registered flags for the result on out0.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept = in_valid & in_ready; operands and opcode are captured on accept and never sampled again for that operation.
REQ-015 Single-cycle ops (0-7, 11-15): IDLE -> DONE on accept; out_valid asserts the cycle after accept (latency 1).
REQ-016 Iterative ops (8-10): IDLE -> BUSY on accept; BUSY lasts exactly WIDTH cycles (one bit per cycle), then DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-017 DONE: out_valid = 1, out0 and flags stable until out_valid & out_ready; then -> IDLE; no accept in that same cycle.
REQ-018 add/sub/and/or/xor: modulo 2^WIDTH; carry = carry-out for add, borrow for sub (1 iff in0 < in1 unsigned), 0 for all other ops.
REQ-019 Shifts use in1[SHW-1:0] as amount; amount >= WIDTH yields 0 for sll/slr and WIDTH copies of in0[WIDTH-1] for sar.
REQ-020 mul: unsigned shift-add, out0 = low WIDTH bits of in0*in1; carry = 1 iff high WIDTH bits non-zero.
REQ-021 divu/remu: unsigned restoring division; out0 = quotient (divu) or remainder (remu).
REQ-022 Divide by zero: quotient = all ones, remainder = in0, carry = 1; same WIDTH-cycle latency.
REQ-023 zero = 1 iff out0 == 0; msb = out0[WIDTH-1]; both computed from the final result, not intermediates.
REQ-024 in_valid while busy/done is ignored (no capture, no state change); upstream holds it.
REQ-025 out_ready while out_valid = 0 has no effect.

Reset
REQ-026 rst asserted at any time, including mid-BUSY, forces IDLE immediately and aborts any operation.
REQ-027 Reset values: out_valid 0, out0 0, zero 1, msb 0, carry 0, iteration counter 0; in_ready 1 once in IDLE.
REQ-028 After rst deasserts, first accept is possible on the first rising edge.

Verification (WIDTH=32)
REQ-029 add 0xFFFFFFFF + 0x00000001, out_ready=1 -> out_valid 1 cycle after accept, out0 0, zero 1, carry 1, msb 0.
REQ-030 sub 3 - 5 -> out0 0xFFFFFFFE, carry 1, msb 1; sar 0x80000000 by 40 -> 0xFFFFFFFF; sll 1 by 32 -> 0, zero 1.
REQ-031 mul 0x00010000 * 0x00010000 -> out_valid exactly 33 cycles after accept, out0 0, carry 1, zero 1; in_ready 0 throughout.
REQ-032 divu 100/7 -> 14, remu 100/7 -> 2; divu 5/0 -> 0xFFFFFFFF carry 1; remu 5/0 -> 5 carry 1.
REQ-033 Backpressure: out_ready 0 for 5 cycles after add result -> out0/flags unchanged, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next cycle.
REQ-034 rst pulsed 10 cycles into divu -> out_valid 0, out0 0, zero 1 during rst; following add 2+2 -> out0 4 with latency 1.
